// File: rtl/otter_pkg.sv
// Shared types for the OTTER pipeline control slice: PC mux encodings,
// major opcodes and the flow-controller state constants.
package otter_pkg;

    typedef enum logic [2:0] {
        PC_PLUS4  = 3'b000,
        PC_JALR   = 3'b001,
        PC_BRANCH = 3'b010,
        PC_JAL    = 3'b011,
        PC_INT    = 3'b100,
        PC_MRET   = 3'b101
    } pc_src_t;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_SYS    = 7'b1110011
    } opcode_t;

    typedef logic [1:0] flow_state_t;

    localparam flow_state_t RUN   = 2'd0;
    localparam flow_state_t FLUSH = 2'd1;
    localparam flow_state_t DRAIN = 2'd2;
    localparam flow_state_t TAKE  = 2'd3;

endpackage

// File: rtl/otter_load_use_det.sv
// Load-use hazard detect: the EX load writes a register the ID instruction reads.
// Purely combinational; x0 never creates a dependency.
module otter_load_use_det (
    input  logic       ex_valid,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = id_rs1_used && (id_rs1 == ex_rd);
        rs2_hit  = id_rs2_used && (id_rs2 == ex_rd);
        load_use = ex_valid && ex_is_load && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/otter_flow_ctrl.sv
// OTTER pipeline flow controller: PC select/enable and IF/ID, ID/EX stall/flush.
// Define OTTER_FLOW_PERF_EN to add the STALL_CNT / FLUSH_CNT performance counters.
//
// state | meaning
// RUN   | normal issue; handles load-use bubbles, redirects and interrupt entry
// FLUSH | one cycle after a redirect/vector; squashes the wrong-path fetch
// DRAIN | fetch held off while older instructions retire before interrupt entry
// TAKE  | INT_TAKEN pulse, PC <- mtvec
module otter_flow_ctrl
    import otter_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EX_VALID,
    input  logic [2:0]  EX_PC_SRC,
    input  logic [4:0]  EX_RD,
    input  logic        EX_IS_LOAD,
    input  logic [4:0]  ID_RS1,
    input  logic [4:0]  ID_RS2,
    input  logic        ID_RS1_USED,
    input  logic        ID_RS2_USED,
    input  logic        MEM_BUSY,
    input  logic        INTR,
    input  logic        MIE,
    output logic [2:0]  PC_SEL,
    output logic        PC_WRITE,
    output logic        IF_ID_WRITE,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_FLUSH,
    output logic        INT_TAKEN
`ifdef OTTER_FLOW_PERF_EN
    ,
    output logic [31:0] STALL_CNT,
    output logic [31:0] FLUSH_CNT
`endif
);

    localparam int CW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(DRAIN_CYCLES - 1);
    // With a single drain cycle the entry cycle itself is the whole drain.
    localparam flow_state_t DRAIN_NEXT = (DRAIN_CYCLES == 1) ? TAKE : DRAIN;

    flow_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          redirect;
    logic          load_use;

    otter_load_use_det u_load_use_det (
        .ex_valid    (EX_VALID),
        .ex_is_load  (EX_IS_LOAD),
        .ex_rd       (EX_RD),
        .id_rs1      (ID_RS1),
        .id_rs2      (ID_RS2),
        .id_rs1_used (ID_RS1_USED),
        .id_rs2_used (ID_RS2_USED),
        .load_use    (load_use)
    );

    assign redirect = EX_VALID && (EX_PC_SRC != PC_PLUS4);

    always_comb begin
        PC_SEL      = PC_PLUS4;
        PC_WRITE    = 1'b1;
        IF_ID_WRITE = 1'b1;
        IF_ID_FLUSH = 1'b0;
        ID_EX_FLUSH = 1'b0;
        INT_TAKEN   = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;

        if (RST) begin
            PC_WRITE    = 1'b0;
            IF_ID_WRITE = 1'b0;
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
            state_d     = RUN;
            cnt_d       = '0;
        end else if (MEM_BUSY) begin
            PC_WRITE    = 1'b0;
            IF_ID_WRITE = 1'b0;
        end else begin
            case (state_q)
                TAKE: begin
                    INT_TAKEN   = 1'b1;
                    PC_SEL      = PC_INT;
                    IF_ID_FLUSH = 1'b1;
                    ID_EX_FLUSH = 1'b1;
                    state_d     = FLUSH;
                end
                DRAIN: begin
                    IF_ID_FLUSH = 1'b1;
                    // mepc must be the redirect target, so the drain restarts behind it.
                    if (redirect) begin
                        PC_SEL      = EX_PC_SRC;
                        ID_EX_FLUSH = 1'b1;
                        cnt_d       = CNT_RELOAD;
                        state_d     = DRAIN_NEXT;
                    end else begin
                        PC_WRITE = 1'b0;
                        if (cnt_q <= CW'(1)) begin
                            cnt_d   = '0;
                            state_d = TAKE;
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                end
                default: begin
                    if (redirect) begin
                        PC_SEL      = EX_PC_SRC;
                        IF_ID_FLUSH = 1'b1;
                        ID_EX_FLUSH = 1'b1;
                        state_d     = FLUSH;
                    end else if (state_q == FLUSH) begin
                        IF_ID_FLUSH = 1'b1;
                        state_d     = RUN;
                    end else if (load_use) begin
                        PC_WRITE    = 1'b0;
                        IF_ID_WRITE = 1'b0;
                        ID_EX_FLUSH = 1'b1;
                    end else if (INTR && MIE) begin
                        PC_WRITE    = 1'b0;
                        IF_ID_FLUSH = 1'b1;
                        cnt_d       = CNT_RELOAD;
                        state_d     = DRAIN_NEXT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef OTTER_FLOW_PERF_EN
    logic        stall_ev;
    logic        flush_ev;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_ev    = !RST && !MEM_BUSY && (state_q == RUN) && !redirect && load_use;
        flush_ev    = !RST && !MEM_BUSY && ((state_q == TAKE) || redirect);
        stall_cnt_d = stall_cnt_q + {31'd0, stall_ev};
        flush_cnt_d = flush_cnt_q + {31'd0, flush_ev};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign STALL_CNT = stall_cnt_q;
    assign FLUSH_CNT = flush_cnt_q;
`endif

endmodule

// File: tb/tb_otter_flow_ctrl.sv
// Testbench for otter_flow_ctrl: single-cycle vector table from RUN, hand-written
// multi-cycle sequences, then random stimulus against a cycle-count reference model.
module tb_otter_flow_ctrl;

    localparam int D = 3;

    typedef struct packed {
        logic       ev;
        logic [2:0] src;
        logic [4:0] rd;
        logic       ld;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       busy;
        logic       intr;
        logic       mie;
    } ins_t;

    typedef struct packed {
        logic [2:0] sel;
        logic       pw;
        logic       iw;
        logic       fi;
        logic       fe;
        logic       it;
    } outs_t;

    typedef struct {
        string name;
        ins_t  i;
        outs_t o;
    } vec_t;

    localparam outs_t O_RUN   = 8'b000_11000;
    localparam outs_t O_STALL = 8'b000_00010;
    localparam outs_t O_ENTRY = 8'b000_01100;
    localparam outs_t O_DRAIN = 8'b000_01100;
    localparam outs_t O_BUSY  = 8'b000_00000;
    localparam outs_t O_RST   = 8'b000_00110;
    localparam outs_t O_FLUSH = 8'b000_11100;
    localparam outs_t O_TAKE  = 8'b100_11111;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EX_VALID, EX_IS_LOAD, ID_RS1_USED, ID_RS2_USED, MEM_BUSY, INTR, MIE;
    logic [2:0]  EX_PC_SRC;
    logic [4:0]  EX_RD, ID_RS1, ID_RS2;
    logic [2:0]  PC_SEL;
    logic        PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_FLUSH, INT_TAKEN;
`ifdef OTTER_FLOW_PERF_EN
    logic [31:0] STALL_CNT, FLUSH_CNT;
`endif

    int checks = 0;
    int errors = 0;

    // reference model: cycles-to-vector bookkeeping
    int          m_left;
    bit          m_take;
    bit          m_after;
    int unsigned m_stall;
    int unsigned m_flush;

    always #5 CLK = ~CLK;

    otter_flow_ctrl #(.DRAIN_CYCLES(D)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .EX_VALID    (EX_VALID),
        .EX_PC_SRC   (EX_PC_SRC),
        .EX_RD       (EX_RD),
        .EX_IS_LOAD  (EX_IS_LOAD),
        .ID_RS1      (ID_RS1),
        .ID_RS2      (ID_RS2),
        .ID_RS1_USED (ID_RS1_USED),
        .ID_RS2_USED (ID_RS2_USED),
        .MEM_BUSY    (MEM_BUSY),
        .INTR        (INTR),
        .MIE         (MIE),
        .PC_SEL      (PC_SEL),
        .PC_WRITE    (PC_WRITE),
        .IF_ID_WRITE (IF_ID_WRITE),
        .IF_ID_FLUSH (IF_ID_FLUSH),
        .ID_EX_FLUSH (ID_EX_FLUSH),
        .INT_TAKEN   (INT_TAKEN)
`ifdef OTTER_FLOW_PERF_EN
        ,
        .STALL_CNT   (STALL_CNT),
        .FLUSH_CNT   (FLUSH_CNT)
`endif
    );

    function automatic ins_t mkin(input logic ev, input logic [2:0] src, input logic [4:0] rd,
                                  input logic ld, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic u1, input logic u2, input logic busy,
                                  input logic intr, input logic mie);
        ins_t v;
        v.ev = ev; v.src = src; v.rd = rd; v.ld = ld; v.rs1 = rs1; v.rs2 = rs2;
        v.u1 = u1; v.u2 = u2; v.busy = busy; v.intr = intr; v.mie = mie;
        return v;
    endfunction

    function automatic outs_t rdir(input logic [2:0] s);
        outs_t o;
        o = {s, 5'b11110};
        return o;
    endfunction

    task automatic apply(input ins_t v);
        EX_VALID = v.ev; EX_PC_SRC = v.src; EX_RD = v.rd; EX_IS_LOAD = v.ld;
        ID_RS1 = v.rs1; ID_RS2 = v.rs2; ID_RS1_USED = v.u1; ID_RS2_USED = v.u2;
        MEM_BUSY = v.busy; INTR = v.intr; MIE = v.mie;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input outs_t exp);
        outs_t act;
        act = {PC_SEL, PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_FLUSH, INT_TAKEN};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got sel=%b pw=%b iw=%b iff=%b ief=%b it=%b, expected sel=%b pw=%b iw=%b iff=%b ief=%b it=%b",
                     name, $time, act.sel, act.pw, act.iw, act.fi, act.fe, act.it,
                     exp.sel, exp.pw, exp.iw, exp.fi, exp.fe, exp.it);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        apply('0);
        tick();
        RST = 1'b0;
        m_left = -1; m_take = 0; m_after = 0; m_stall = 0; m_flush = 0;
    endtask

    // Expected outputs for one cycle, then advance the model past the clock edge.
    task automatic model_step(input bit rst, input ins_t v, output outs_t exp);
        bit redir, lu;
        redir = v.ev && (v.src != 3'b000);
        lu = v.ev && v.ld && (v.rd != 5'd0) &&
             ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
        if (rst) begin
            exp = O_RST;
            m_left = -1; m_take = 0; m_after = 0; m_stall = 0; m_flush = 0;
        end else if (v.busy) begin
            exp = O_BUSY;
        end else if (m_take) begin
            exp = O_TAKE;
            m_take = 0; m_after = 1; m_flush++;
        end else if (m_left >= 0) begin
            if (redir) begin
                exp = rdir(v.src);
                m_left = D - 1; m_flush++;
            end else begin
                exp = O_DRAIN;
                m_left--;
            end
            if (m_left == 0) begin m_take = 1; m_left = -1; end
        end else if (redir) begin
            exp = rdir(v.src);
            m_after = 1; m_flush++;
        end else if (m_after) begin
            exp = O_FLUSH;
            m_after = 0;
        end else if (lu) begin
            exp = O_STALL;
            m_stall++;
        end else if (v.intr && v.mie) begin
            exp = O_ENTRY;
            m_left = D - 1;
            if (m_left == 0) begin m_take = 1; m_left = -1; end
        end else begin
            exp = O_RUN;
        end
    endtask

    vec_t vecs[$];
    ins_t idle, lu_v, entry_v;

    initial begin
        logic [2:0] srcs[4];
        int         zeros;
        bit         seen;
        outs_t      exp;
        ins_t       v;
        bit         r;

        srcs = '{3'b001, 3'b010, 3'b011, 3'b101};
        idle    = mkin(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lu_v    = mkin(1, 3'b000, 5, 1, 5, 1, 1, 1, 0, 0, 0);
        entry_v = mkin(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        vecs.push_back('{"straight",     mkin(1, 3'b000, 7, 0, 1, 2, 1, 1, 0, 0, 0), O_RUN});
        vecs.push_back('{"lu_rs1",       lu_v,                                        O_STALL});
        vecs.push_back('{"lu_rs2",       mkin(1, 3'b000, 5, 1, 1, 5, 1, 1, 0, 0, 0), O_STALL});
        vecs.push_back('{"lu_x0",        mkin(1, 3'b000, 0, 1, 0, 0, 1, 1, 0, 0, 0), O_RUN});
        vecs.push_back('{"lu_unused",    mkin(1, 3'b000, 5, 1, 5, 2, 0, 1, 0, 0, 0), O_RUN});
        vecs.push_back('{"lu_noload",    mkin(1, 3'b000, 5, 0, 5, 5, 1, 1, 0, 0, 0), O_RUN});
        vecs.push_back('{"lu_invalid",   mkin(0, 3'b000, 5, 1, 5, 5, 1, 1, 0, 0, 0), O_RUN});
        vecs.push_back('{"br",           mkin(1, 3'b010, 3, 0, 1, 2, 1, 1, 0, 0, 0), rdir(3'b010)});
        vecs.push_back('{"jalr",         mkin(1, 3'b001, 3, 0, 1, 2, 1, 1, 0, 0, 0), rdir(3'b001)});
        vecs.push_back('{"jal",          mkin(1, 3'b011, 3, 0, 1, 2, 1, 1, 0, 0, 0), rdir(3'b011)});
        vecs.push_back('{"mret",         mkin(1, 3'b101, 0, 0, 0, 0, 0, 0, 0, 0, 0), rdir(3'b101)});
        vecs.push_back('{"br_invalid",   mkin(0, 3'b010, 3, 0, 1, 2, 1, 1, 0, 0, 0), O_RUN});
        vecs.push_back('{"intr",         entry_v,                                     O_ENTRY});
        vecs.push_back('{"intr_nomie",   mkin(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_RUN});
        vecs.push_back('{"busy_br",      mkin(1, 3'b010, 5, 1, 5, 5, 1, 1, 1, 1, 1), O_BUSY});
        vecs.push_back('{"rdir_over_lu", mkin(1, 3'b010, 5, 1, 5, 1, 1, 1, 0, 0, 0), rdir(3'b010)});
        vecs.push_back('{"lu_over_intr", mkin(1, 3'b000, 5, 1, 5, 1, 1, 1, 0, 1, 1), O_STALL});
        vecs.push_back('{"jal_over_int", mkin(1, 3'b011, 0, 0, 0, 0, 0, 0, 0, 1, 1), rdir(3'b011)});

        RST = 1'b1;
        apply(idle);
        #1 check("reset_outs", O_RST);
        tick();

        foreach (vecs[k]) begin
            do_reset();
            apply(vecs[k].i);
            #1 check(vecs[k].name, vecs[k].o);
        end

        // load-use bubble lasts exactly one cycle
        do_reset();
        apply(lu_v);
        #1 check("lu_seq_stall", O_STALL);
        tick();
        apply(mkin(0, 3'b000, 5, 0, 5, 1, 1, 1, 0, 0, 0));
        #1 check("lu_seq_after", O_RUN);

        // branch: redirect, then one flush cycle, then run
        do_reset();
        apply(vecs[7].i);
        #1 check("br_seq_redir", rdir(3'b010));
        tick();
        apply(idle);
        #1 check("br_seq_flush", O_FLUSH);
        tick();
        #1 check("br_seq_run", O_RUN);

        // interrupt entry: fetch held D cycles, then the vector; INTR drops mid-drain
        do_reset();
        apply(entry_v);
        zeros = 0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (INT_TAKEN) begin
                seen = 1;
                check("int_take", O_TAKE);
            end else if (!PC_WRITE) begin
                zeros++;
            end
            tick();
            apply(idle);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL int_timeout: got no INT_TAKEN in 20 cycles, expected one");
        end
        check_val("int_hold_cycles", zeros, D);
        #1 check("int_post_flush", O_FLUSH);
        tick();
        #1 check("int_post_run", O_RUN);

        // MIE clear: interrupt ignored
        do_reset();
        apply(mkin(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int c = 0; c < 6; c++) begin
            #1 check("nomie_run", O_RUN);
            tick();
        end

        // JAL in drain: applied, drain restarts, vector D cycles later
        do_reset();
        apply(entry_v);
        #1 check("jal_dr_entry", O_ENTRY);
        tick();
        apply(idle);
        #1 check("jal_dr_drain", O_DRAIN);
        tick();
        apply(mkin(1, 3'b011, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 check("jal_dr_redir", rdir(3'b011));
        tick();
        apply(idle);
        for (int c = 1; c < D; c++) begin
            #1 check("jal_dr_redrain", O_DRAIN);
            tick();
        end
        #1 check("jal_dr_take", O_TAKE);

        // MEM_BUSY freezes the drain counter
        do_reset();
        apply(entry_v);
        tick();
        apply(idle);
        #1 check("busy_dr_drain", O_DRAIN);
        tick();
        apply(mkin(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int c = 0; c < 4; c++) begin
            #1 check("busy_dr_frozen", O_BUSY);
            tick();
        end
        apply(idle);
        #1 check("busy_dr_resume", O_DRAIN);
        tick();
        #1 check("busy_dr_take", O_TAKE);

        // reset mid-drain abandons the interrupt
        do_reset();
        apply(entry_v);
        tick();
        apply(idle);
        tick();
        RST = 1'b1;
        #1 check("rst_dr_outs", O_RST);
        tick();
        RST = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1 check("rst_dr_run", O_RUN);
            tick();
        end

        // random stimulus against the reference model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 63) == 0);
            v.ev   = ($urandom_range(0, 3) != 0);
            v.src  = ($urandom_range(0, 7) == 0) ? srcs[$urandom_range(0, 3)] : 3'b000;
            v.rd   = 5'($urandom_range(0, 3));
            v.ld   = 1'($urandom_range(0, 1));
            v.rs1  = 5'($urandom_range(0, 3));
            v.rs2  = 5'($urandom_range(0, 3));
            v.u1   = 1'($urandom_range(0, 1));
            v.u2   = 1'($urandom_range(0, 1));
            v.busy = ($urandom_range(0, 7) == 0);
            v.intr = ($urandom_range(0, 3) == 0);
            v.mie  = 1'($urandom_range(0, 1));
            RST = r;
            apply(v);
            model_step(r, v, exp);
            #1 check("rand", exp);
            tick();
`ifdef OTTER_FLOW_PERF_EN
            if (n % 100 == 99) begin
                check_val("rand_stall_cnt", STALL_CNT, m_stall);
                check_val("rand_flush_cnt", FLUSH_CNT, m_flush);
            end
`endif
        end
        RST = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
